// File: rtl/reg_seq_pkg.sv
// Shared opcode encodings and pulse-vector helpers for the register sequencer
// and any bench that models the driven register.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHR  = 3'd5,
        OP_SHL  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Pulse vector bit order is {cl, ld, inc, dec, sr, sl}
    localparam int PULSE_SR = 1;
    localparam int PULSE_SL = 0;

    function automatic logic [5:0] op_pulse(input op_e op);
        logic [5:0] vec;
        vec = '0;
        case (op)
            OP_CLR:  vec = 6'b100000;
            OP_LOAD: vec = 6'b010000;
            OP_INC:  vec = 6'b001000;
            OP_DEC:  vec = 6'b000100;
            OP_SHR:  vec = 6'b000010;
            OP_SHL:  vec = 6'b000001;
            default: vec = '0;
        endcase
        return vec;
    endfunction

    function automatic logic is_repeat_op(input op_e op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/reg_sequencer.sv
// Command sequencer that turns CLR/LOAD/INC/DEC/SHR/SHL commands into registered
// control pulses for a downstream shift/count register.
module reg_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AMT_WIDTH-1:0]  cmd_amt,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_fill,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic                  ir,
    output logic                  il,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    localparam logic [AMT_WIDTH-1:0] CNT_ONE = AMT_WIDTH'(1);
    localparam logic [AMT_WIDTH-1:0] CNT_TWO = AMT_WIDTH'(2);

    state_e                  state_q, state_d;
    logic [AMT_WIDTH-1:0]    cnt_q, cnt_d;
    op_e                     op_q, op_d;
    logic                    fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [5:0]              pulse_q, pulse_d;
    logic                    ir_q, ir_d;
    logic                    il_q, il_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            fill_q  <= 1'b0;
            data_q  <= '0;
            pulse_q <= '0;
            ir_q    <= 1'b0;
            il_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
            ir_q    <= ir_d;
            il_q    <= il_d;
            done_q  <= done_d;
        end
    end

    // cnt_q holds the EXEC cycles left including the current one, so every
    // output for cycle k+1 is decided at the accepting edge and stays registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        data_d  = data_q;
        pulse_d = '0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    fill_d  = cmd_fill;
                    data_d  = cmd_data;
                    state_d = EXEC;
                    if (is_repeat_op(op_d) && (cmd_amt != '0)) begin
                        cnt_d   = cmd_amt;
                        pulse_d = op_pulse(op_d);
                    end else begin
                        cnt_d = CNT_ONE;
                        if (!is_repeat_op(op_d)) begin
                            pulse_d = op_pulse(op_d);
                        end
                    end
                    done_d = (cnt_d == CNT_ONE);
                end
            end
            EXEC: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    pulse_d = op_pulse(op_q);
                    done_d  = (cnt_q == CNT_TWO);
                end
            end
            default: state_d = IDLE;
        endcase

        ir_d = pulse_d[PULSE_SR] & fill_d;
        il_d = pulse_d[PULSE_SL] & fill_d;
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == EXEC);
    assign {cl, ld, inc, dec, sr, sl} = pulse_q;
    assign ir        = ir_q;
    assign il        = il_q;
    assign done      = done_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer: cycle-by-cycle pulse checks, a behavioural
// downstream register, reset abort, and a random command stream with pulse tallies.
module tb_reg_sequencer;
    import reg_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_amt;
    logic [15:0] cmd_data;
    logic        cmd_fill;
    logic        cl, ld, inc, dec, sr, sl, ir, il;
    logic [15:0] data_out;
    logic        busy, done;

    int check_count = 0;
    int pass_count  = 0;

    logic [15:0] model_reg = '0;
    int pulse_cnt [1:6];
    int done_cnt    = 0;
    int onehot_err  = 0;

    reg_sequencer #(.DATA_WIDTH(16), .AMT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
        .ir(ir), .il(il), .data_out(data_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register driven by the control pulses
    always @(posedge clk) begin
        if (cl)       model_reg <= '0;
        else if (ld)  model_reg <= data_out;
        else if (inc) model_reg <= model_reg + 16'd1;
        else if (dec) model_reg <= model_reg - 16'd1;
        else if (sr)  model_reg <= {ir, model_reg[15:1]};
        else if (sl)  model_reg <= {model_reg[14:0], il};
    end

    initial for (int i = 1; i <= 6; i++) pulse_cnt[i] = 0;

    always @(negedge clk) begin
        if ($countones({cl, ld, inc, dec, sr, sl}) > 1) onehot_err <= onehot_err + 1;
        if (cmd_ready && ({cl, ld, inc, dec, sr, sl} != 6'b0)) onehot_err <= onehot_err + 1;
        if (cl)   pulse_cnt[1] <= pulse_cnt[1] + 1;
        if (ld)   pulse_cnt[2] <= pulse_cnt[2] + 1;
        if (inc)  pulse_cnt[3] <= pulse_cnt[3] + 1;
        if (dec)  pulse_cnt[4] <= pulse_cnt[4] + 1;
        if (sr)   pulse_cnt[5] <= pulse_cnt[5] + 1;
        if (sl)   pulse_cnt[6] <= pulse_cnt[6] + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    endtask

    function automatic logic [31:0] outVec();
        return {21'b0, cmd_ready, busy, done, cl, ld, inc, dec, sr, sl, ir, il};
    endfunction

    // Presents a command and returns #1 after its accepting edge (cycle k+1)
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] amt,
                                 input logic [15:0] data, input logic fill);
        int waited;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_fill  = fill;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) checkOutput("ready_timeout", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Checks every EXEC cycle plus the first IDLE cycle after it; leaves time in that IDLE cycle
    task automatic checkExec(input string tag, input logic [5:0] exp_pulse,
                             input int exp_n, input logic fill);
        int cycles;
        logic [31:0] exp;
        logic ir_e, il_e;
        cycles = (exp_n == 0) ? 1 : exp_n;
        for (int c = 1; c <= cycles; c++) begin
            ir_e = (exp_pulse == 6'b000010) && (c <= exp_n) && fill;
            il_e = (exp_pulse == 6'b000001) && (c <= exp_n) && fill;
            exp  = {21'b0, 1'b0, 1'b1, (c == cycles),
                    ((c <= exp_n) ? exp_pulse : 6'b0), ir_e, il_e};
            checkOutput(tag, outVec(), exp);
            @(posedge clk); #1;
        end
        checkOutput({tag, "_end"}, outVec(), {21'b0, 11'b100_0000_0000});
    endtask

    int sl_base;
    int base_cnt [1:6];
    int exp_cnt  [1:6];
    int base_done;
    int n_cmds;
    logic [2:0] r_op;
    logic [3:0] r_amt;
    int guard;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0; cmd_fill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", outVec(), {21'b0, 11'b100_0000_0000});
        checkOutput("reset_data", {16'b0, data_out}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        applyStimulus(OP_LOAD, 4'd7, 16'hA5C3, 1'b0);
        checkOutput("load_data", {16'b0, data_out}, 32'h0000A5C3);
        checkExec("load", 6'b010000, 1, 1'b0);
        checkOutput("load_reg", {16'b0, model_reg}, 32'h0000A5C3);

        applyStimulus(OP_LOAD, 4'd0, 16'h0008, 1'b0);
        checkExec("load8", 6'b010000, 1, 1'b0);
        applyStimulus(OP_SHR, 4'd3, 16'h1234, 1'b1);
        checkExec("shr3", 6'b000010, 3, 1'b1);
        checkOutput("shr_reg", {16'b0, model_reg}, 32'h0000E001);
        checkOutput("shr_data", {16'b0, data_out}, 32'h00001234);

        applyStimulus(OP_INC, 4'd0, 16'h0, 1'b0);
        checkExec("inc0", 6'b001000, 0, 1'b0);
        applyStimulus(OP_NOP, 4'd5, 16'h0, 1'b1);
        checkExec("nop", 6'b000000, 0, 1'b1);
        applyStimulus(OP_RSVD, 4'd3, 16'h0, 1'b1);
        checkExec("rsvd", 6'b000000, 0, 1'b1);
        checkOutput("nop_reg", {16'b0, model_reg}, 32'h0000E001);

        applyStimulus(OP_CLR, 4'd9, 16'h0, 1'b0);
        checkExec("clr", 6'b100000, 1, 1'b0);
        applyStimulus(OP_DEC, 4'd15, 16'h0, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_amt = 4'd2; cmd_data = 16'hBEEF;
        checkExec("dec15", 6'b000100, 15, 1'b0);
        checkOutput("dec_reg", {16'b0, model_reg}, 32'h0000FFF1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("held_clr_data", {16'b0, data_out}, 32'h0000BEEF);
        checkExec("held_clr", 6'b100000, 1, 1'b0);

        applyStimulus(OP_SHL, 4'd2, 16'h0, 1'b1);
        checkExec("shl2", 6'b000001, 2, 1'b1);
        applyStimulus(OP_INC, 4'd4, 16'h0, 1'b0);
        checkExec("inc4", 6'b001000, 4, 1'b0);
        checkOutput("inc_reg", {16'b0, model_reg}, 32'h00000007);

        sl_base = pulse_cnt[6];
        applyStimulus(OP_SHL, 4'd5, 16'h5555, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outs", outVec(), {21'b0, 11'b100_0000_0000});
        checkOutput("abort_data", {16'b0, data_out}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        applyStimulus(OP_CLR, 4'd0, 16'h0, 1'b0);
        checkExec("post_rst_clr", 6'b100000, 1, 1'b0);
        checkOutput("abort_sl_count", pulse_cnt[6], sl_base + 1);

        for (int i = 1; i <= 6; i++) begin base_cnt[i] = pulse_cnt[i]; exp_cnt[i] = 0; end
        base_done = done_cnt;
        n_cmds = 20;
        for (int j = 0; j < n_cmds; j++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_amt = 4'($urandom_range(0, 15));
            if (r_op == OP_CLR || r_op == OP_LOAD) exp_cnt[r_op] = exp_cnt[r_op] + 1;
            else if (r_op >= OP_INC && r_op <= OP_SHL) exp_cnt[r_op] = exp_cnt[r_op] + int'(r_amt);
            applyStimulus(r_op, r_amt, 16'($urandom), 1'($urandom));
        end
        guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("rand_idle", {31'b0, busy}, 32'd0);
        checkOutput("rand_cl",   pulse_cnt[1] - base_cnt[1], exp_cnt[1]);
        checkOutput("rand_ld",   pulse_cnt[2] - base_cnt[2], exp_cnt[2]);
        checkOutput("rand_inc",  pulse_cnt[3] - base_cnt[3], exp_cnt[3]);
        checkOutput("rand_dec",  pulse_cnt[4] - base_cnt[4], exp_cnt[4]);
        checkOutput("rand_sr",   pulse_cnt[5] - base_cnt[5], exp_cnt[5]);
        checkOutput("rand_sl",   pulse_cnt[6] - base_cnt[6], exp_cnt[6]);
        checkOutput("rand_done", done_cnt - base_done, n_cmds);
        checkOutput("onehot",    onehot_err, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
